// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered, handshaked N-channel arbiter between the L1
// caches and the single main-memory port. One word transaction at a time is
// serialised onto the memory bus. Read data and a one-cycle completion pulse
// go back to the granted requester.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN - when defined, the lowest-index pending channel
//                           (channel 0, the data cache) always wins and no
//                           round-robin pointer exists. When undefined
//                           (default), arbitration is round-robin.
//
// Parameters:
//   NCH  number of requesting channels (>= 2); ch0 = D-cache, ch1 = I-cache
//   AW   address width
//   DW   data width
//   IDW  grant_id width, derived as $clog2(NCH)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_rd     per-channel read request (level, held until req_ready)
//   req_wr     per-channel write request (level, held until req_ready)
//   req_addr   packed per-channel addresses, channel i at [i*AW +: AW]
//   req_wdata  packed per-channel write data, channel i at [i*DW +: DW]
//   req_rdata  shared read data, valid in the req_ready cycle
//   req_ready  one-hot one-cycle completion pulse
//   mem_oe     memory read strobe
//   mem_we     memory write strobe
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory completion, only looked at in BUSY
//   busy       high whenever the arbiter is not IDLE
//   grant_id   index of the current or most recent grant
module mem_port_arbiter #(
  parameter  int unsigned NCH = 2,
  parameter  int unsigned AW  = 32,
  parameter  int unsigned DW  = 32,
  localparam int unsigned IDW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_rd,
  input  logic [NCH-1:0]    req_wr,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [DW-1:0]     req_rdata,
  output logic [NCH-1:0]    req_ready,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_d;
  logic [IDW-1:0] grant_id_d;
  logic           mem_oe_d;
  logic           mem_we_d;
  logic [AW-1:0]  mem_addr_d;
  logic [DW-1:0]  mem_wdata_d;
  logic [DW-1:0]  req_rdata_d;
  logic [NCH-1:0] req_ready_d;
  logic           busy_d;

  logic [NCH-1:0] pend;
  logic           any_pend;
  logic [IDW-1:0] win;

  logic [AW-1:0]  addr_a  [NCH];
  logic [DW-1:0]  wdata_a [NCH];

  // Unpack the flat per-channel buses.
  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
  end

  assign pend     = req_rd | req_wr;
  assign any_pend = |pend;

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest-index pending channel wins.
  always_comb begin
    logic found;
    logic [IDW-1:0] c;
    win   = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = IDW'(k);
      if (!found && pend[c]) begin
        win   = c;
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_d;

  // First pending channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    logic found;
    logic [IDW-1:0] c;
    win   = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = IDW'((32'(rr_ptr) + k) % NCH);
      if (!found && pend[c]) begin
        win   = c;
        found = 1'b1;
      end
    end
  end
`endif

  // Next-state and next-output logic; every output is a flop fed from here.
  always_comb begin
    state_d     = state;
    grant_id_d  = grant_id;
    mem_oe_d    = mem_oe;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    req_rdata_d = req_rdata;
    req_ready_d = '0;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_ptr_d    = rr_ptr;
`endif

    case (state)
      S_IDLE: begin
        if (any_pend) begin
          state_d     = S_BUSY;
          grant_id_d  = win;
          // Write dominates when a channel raises both rd and wr.
          mem_we_d    = req_wr[win];
          mem_oe_d    = ~req_wr[win];
          mem_addr_d  = addr_a[win];
          mem_wdata_d = wdata_a[win];
`ifndef ARB_FIXED_PRIORITY_EN
          rr_ptr_d    = IDW'((32'(win) + 32'd1) % NCH);
`endif
        end
      end

      S_BUSY: begin
        if (mem_ready) begin
          state_d = S_RELEASE;
          if (mem_oe) begin
            req_rdata_d = mem_rdata;
          end
          req_ready_d[grant_id] = 1'b1;
          mem_oe_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end

      S_RELEASE: begin
        // Gap cycle so the requester can drop its level request.
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        mem_oe_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops strobes asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_rdata <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_d;
      grant_id  <= grant_id_d;
      mem_oe    <= mem_oe_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      req_rdata <= req_rdata_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = $clog2(NCH);

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    req_rd;
  logic [NCH-1:0]    req_wr;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [DW-1:0]     req_rdata;
  logic [NCH-1:0]    req_ready;
  logic              mem_oe;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_ready (req_ready),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: next round-robin start, last read data, last grant.
  int            ptr = 0;
  logic [DW-1:0] exp_rdata = '0;
  int            last_w = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner according to the arbitration rule of the current build.
  function automatic int pick(input logic [NCH-1:0] pend);
    int start;
`ifdef ARB_FIXED_PRIORITY_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NCH; k++)
      if (pend[(start + k) % NCH]) return (start + k) % NCH;
    return -1;
  endfunction

  task automatic new_req(input int c);
    int op;
    op = int'($urandom_range(7, 0));
    req_rd[c] = (op == 0) || (op >= 4);
    req_wr[c] = (op <= 3);
    req_addr[c*AW +: AW]  = $urandom;
    req_wdata[c*DW +: DW] = $urandom;
  endtask

  // One full transaction starting at a negedge while IDLE with work pending.
  // lat: BUSY cycles until mem_ready; wd: BUSY cycle in which the granted
  // channel withdraws (0 = never); rv: read data returned by memory.
  task automatic serve(input int lat, input int wd, input logic [DW-1:0] rv, output int gw);
    logic [NCH-1:0] oh;
    logic           wr;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    int             w;
    w = pick(req_rd | req_wr);
    gw = w;
    if (w < 0) begin
      chk("serve_no_pending", 1, 0);
      return;
    end
    wr = req_wr[w];
    a  = req_addr[w*AW +: AW];
    d  = req_wdata[w*DW +: DW];
    mem_ready = 1'($urandom_range(1, 0));   // must be ignored outside BUSY
    mem_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    ptr = (w + 1) % NCH;
`endif
    last_w = w;
    chk("grant_id", grant_id, w);
    chk("busy_on", busy, 1);
    chk("mem_we", mem_we, wr);
    chk("mem_oe", mem_oe, !wr);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    for (int c = 1; c <= lat; c++) begin
      if (c == wd) begin
        req_rd[w] = 1'b0;
        req_wr[w] = 1'b0;
      end
      if (c > 1) begin
        chk("hold_oe", mem_oe, !wr);
        chk("hold_we", mem_we, wr);
        chk("hold_addr", mem_addr, a);
      end
      chk("ready_early", req_ready, 0);
      mem_rdata = $urandom;
      if (c == lat) begin
        mem_rdata = rv;
        mem_ready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    if (!wr) exp_rdata = rv;
    oh = '0;
    oh[w] = 1'b1;
    chk("req_ready", req_ready, oh);
    chk("req_rdata", req_rdata, exp_rdata);
    chk("rel_oe", mem_oe, 0);
    chk("rel_we", mem_we, 0);
    chk("rel_busy", busy, 1);
    req_rd[w] = 1'b0;
    req_wr[w] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_drop", req_ready, 0);
    chk("busy_off", busy, 0);
    chk("idle_oe", mem_oe, 0);
    chk("idle_gid", grant_id, w);
  endtask

  initial begin
    int w;
    int g [6];
    int lat;
    int wd;

    reset = 1'b0;
    req_rd = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // Reset values.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_oe", mem_oe, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Simultaneous: ch0 reads 0x10, ch1 writes 0x55 to 0x20; ch0 first.
    req_rd[0] = 1'b1; req_addr[0*AW +: AW] = 32'h10;
    req_wr[1] = 1'b1; req_addr[1*AW +: AW] = 32'h20; req_wdata[1*DW +: DW] = 32'h55;
    serve(2, 0, 32'h1234_5678, w);
    chk("sim_first", w, 0);
    serve(1, 0, 32'hCAFE_0001, w);
    chk("sim_second", w, 1);
    chk("sim_rdata_kept", req_rdata, 32'h1234_5678);

    // Single read: ch1 at 0x40, memory answers after 5 BUSY cycles.
    req_rd[1] = 1'b1; req_addr[1*AW +: AW] = 32'h40;
    serve(5, 0, 32'hDEAD_BEEF, w);
    chk("single_gid", w, 1);

    // Both rd and wr on ch0: treated as a write.
    req_rd[0] = 1'b1; req_wr[0] = 1'b1;
    req_addr[0*AW +: AW] = 32'h80; req_wdata[0*DW +: DW] = 32'hA5;
    serve(1, 0, 32'h0BAD_0BAD, w);
    chk("both_rdata_kept", req_rdata, 32'hDEAD_BEEF);

    // Withdrawn read: ch0 drops its request two cycles into BUSY.
    req_rd[0] = 1'b1; req_addr[0*AW +: AW] = 32'h90;
    serve(4, 3, 32'h7777_1111, w);

    // Fairness: both channels keep requesting; served channel re-requests.
    req_rd[0] = 1'b1; req_addr[0*AW +: AW] = 32'h100;
    req_rd[1] = 1'b1; req_addr[1*AW +: AW] = 32'h200;
    for (int i = 0; i < 6; i++) begin
      serve(1 + (i % 2), 0, $urandom, w);
      g[i] = w;
      req_rd[w] = 1'b1;
      req_addr[w*AW +: AW] = $urandom;
    end
    for (int i = 1; i < 6; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      chk("fair_fixed", g[i], 0);
`else
      chk("fair_alt", g[i], 1 - g[i-1]);
`endif
    end
    req_rd = '0;
    req_wr = '0;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCH; c++)
        if (!(req_rd[c] | req_wr[c]) && ($urandom_range(1, 0) == 1)) new_req(c);
      if ((req_rd | req_wr) == '0) begin
        @(posedge clk); @(negedge clk);
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_gid", grant_id, last_w);
        new_req(int'($urandom_range(NCH - 1, 0)));
      end
      lat = int'($urandom_range(4, 1));
      wd  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(lat, 1)) : 0;
      serve(lat, wd, $urandom, w);
    end

    // Reset in the middle of a transaction.
    req_rd = '0;
    req_wr = '0;
    req_rd[1] = 1'b1; req_addr[1*AW +: AW] = 32'h44;
    @(posedge clk); @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    chk("mid_gid_pre", grant_id, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_oe", mem_oe, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_gid", grant_id, 0);
    req_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    ptr = 0;
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(1, 0));
      @(posedge clk); @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_gid", grant_id, 0);
      chk("post_ready", req_ready, 0);
    end
    mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
